// File: rtl/prim_arbiter_wrr_pkt_pkg.sv
// prim_arbiter_pkg: shared types for the weighted round-robin packet arbiter.
// Holds the arbiter lock state enum, used by the top level and exposed on its
// debug port.
package prim_arbiter_pkg;

  // ArbFree: a new winner may be chosen this cycle.
  // ArbBusy: a multi-beat packet is in flight and the winner is locked.
  typedef enum logic [0:0] {
    ArbFree = 1'b0,
    ArbBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prim_arbiter_wrr_pkt_if.sv
// prim_arbiter_wrr_pkt_if: request/grant bundle between N packet sources and
// one sink, routed through prim_arbiter_wrr_pkt.
//   req_i/last_i/data_i : per-port beat request, last-beat flag and data
//   weight_i            : per-port packets-per-round
//   gnt_o/idx_o         : one-hot grant and winner index
//   valid_o/data_o/last_o/ready_i : beat offered to the sink and its backpressure
// Handshake: a beat transfers on a cycle where valid_o && ready_i. A source
// keeps req_i (and its last_i/data_i) stable until its gnt_o bit is seen; the
// arbiter keeps idx_o stable while valid_o is high and ready_i is low.
// Modports: slave = arbiter side, master = sources + sink side.
interface prim_arbiter_wrr_pkt_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int WW = 4
);
  localparam int IdxW = $clog2(N);

  logic [N-1:0]    req_i;
  logic [N-1:0]    last_i;
  logic [DW-1:0]   data_i   [N];
  logic [WW-1:0]   weight_i [N];
  logic [N-1:0]    gnt_o;
  logic [IdxW-1:0] idx_o;
  logic            valid_o;
  logic [DW-1:0]   data_o;
  logic            last_o;
  logic            ready_i;

  modport slave (
    input  req_i, last_i, data_i, weight_i, ready_i,
    output gnt_o, idx_o, valid_o, data_o, last_o
  );

  modport master (
    output req_i, last_i, data_i, weight_i, ready_i,
    input  gnt_o, idx_o, valid_o, data_o, last_o
  );
endinterface

// File: rtl/prim_arbiter_wrr_pkt_pick.sv
// prim_rr_pick: combinational round-robin picker.
// Finds the first set bit of req_i scanning ptr_i, ptr_i+1, ... modulo N.
//   req_i    : candidate mask
//   ptr_i    : scan start index (always < N)
//   onehot_o : one-hot of the chosen index (0 when nothing set)
//   idx_o    : chosen index (0 when nothing set)
//   found_o  : any bit set in req_i
module prim_rr_pick #(
  parameter  int N    = 4,
  localparam int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  logic [N-1:0]    w_rot;
  logic [IdxW-1:0] w_lead;
  int              w_sum;

  // Rotate so that position 0 corresponds to ptr_i.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      w_rot[i] = req_i[IdxW'((i + int'(ptr_i)) % N)];
    end
  end

  // Lowest set bit of the rotated mask.
  always_comb begin
    found_o = 1'b0;
    w_lead  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found_o = 1'b1;
        w_lead  = IdxW'(i);
      end
    end
  end

  // Un-rotate; both operands are < N so one conditional subtract suffices,
  // which also keeps non-power-of-2 N correct.
  always_comb begin
    w_sum = int'(w_lead) + int'(ptr_i);
    if (w_sum >= N) w_sum = w_sum - N;
    idx_o    = found_o ? IdxW'(w_sum) : '0;
    onehot_o = found_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/prim_arbiter_wrr_pkt.sv
// prim_arbiter_wrr_pkt: N:1 weighted round-robin packet arbiter.
// Grants whole packets, locking the winner until its last beat is accepted.
// Each port may win up to weight_i[p] consecutive packets per round; credits
// are reloaded from weight_i when a packet completes and its port had no
// credit left.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : slave side of prim_arbiter_wrr_pkt_if
//   dbg_st_o      : lock state (ArbFree/ArbBusy)
//   dbg_ptr_o     : round-robin scan pointer
module prim_arbiter_wrr_pkt
  import prim_arbiter_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int DW         = 32,
  parameter  int WW         = 4,
  parameter  bit EnDataPort = 1'b1,
  localparam int IdxW       = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  prim_arbiter_wrr_pkt_if.slave  bus,
  output arb_state_e             dbg_st_o,
  output logic [IdxW-1:0]        dbg_ptr_o
);

  arb_state_e      r_st;
  logic [IdxW-1:0] r_cur;
  logic [IdxW-1:0] r_ptr;
  logic [WW-1:0]   r_credit [N];

  logic [N-1:0]    w_elig, w_oh_e, w_oh_r, w_win_oh, w_idx_oh;
  logic [IdxW-1:0] w_idx_e, w_idx_r, w_win, w_idx, w_ptr_nxt;
  logic            w_found_e, w_found_r;
  logic            w_valid, w_last, w_acc, w_done, w_reload;
  logic [WW-1:0]   w_base, w_rem;

  function automatic logic [WW-1:0] wt_min1(input logic [WW-1:0] w);
    return (w == '0) ? WW'(1) : w;
  endfunction

  always_comb begin
    w_elig = '0;
    for (int p = 0; p < N; p++) begin
      w_elig[p] = bus.req_i[p] & (r_credit[p] != '0);
    end
  end

  prim_rr_pick #(.N(N)) u_pick_elig (
    .req_i(w_elig), .ptr_i(r_ptr), .onehot_o(w_oh_e), .idx_o(w_idx_e), .found_o(w_found_e)
  );

  prim_rr_pick #(.N(N)) u_pick_req (
    .req_i(bus.req_i), .ptr_i(r_ptr), .onehot_o(w_oh_r), .idx_o(w_idx_r), .found_o(w_found_r)
  );

  // Credited requesters win first; otherwise fall back to any requester.
  assign w_win    = w_found_e ? w_idx_e : w_idx_r;
  assign w_win_oh = w_found_e ? w_oh_e  : w_oh_r;

  assign w_idx    = (r_st == ArbBusy) ? r_cur : w_win;
  assign w_idx_oh = (r_st == ArbBusy) ? (N'(1) << r_cur) : w_win_oh;
  assign w_valid  = (r_st == ArbBusy) ? bus.req_i[r_cur] : w_found_r;
  assign w_last   = w_valid & bus.last_i[w_idx];
  assign w_acc    = w_valid & bus.ready_i;
  assign w_done   = w_acc & w_last;

  // A winner with zero credit can only come from the fallback pick, so that
  // condition marks a reload round; credits do not move while locked, so the
  // same test holds at the end of a locked packet.
  assign w_reload = (r_credit[w_idx] == '0);
  assign w_base   = w_reload ? wt_min1(bus.weight_i[w_idx]) : r_credit[w_idx];
  assign w_rem    = (w_base != '0) ? (w_base - 1'b1) : '0;

  // Keep the pointer on the winner while it still has credit so it can take
  // its next packet; otherwise move past it, wrapping at N-1.
  assign w_ptr_nxt = (w_rem != '0)              ? w_idx :
                     (w_idx == IdxW'(N - 1))    ? '0    : (w_idx + 1'b1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st  <= ArbFree;
      r_cur <= '0;
      r_ptr <= '0;
      for (int p = 0; p < N; p++) r_credit[p] <= '0;
    end else begin
      case (r_st)
        ArbFree: begin
          if (w_valid && !(bus.ready_i && w_last)) begin
            r_st  <= ArbBusy;
            r_cur <= w_win;
          end
        end
        ArbBusy: begin
          if (w_done) r_st <= ArbFree;
        end
        default: r_st <= ArbFree;
      endcase

      if (w_done) begin
        if (w_reload) begin
          for (int p = 0; p < N; p++) r_credit[p] <= wt_min1(bus.weight_i[p]);
        end
        // Later assignment overrides the reload value for the winner.
        r_credit[w_idx] <= w_rem;
        r_ptr           <= w_ptr_nxt;
      end
    end
  end

  assign bus.idx_o   = w_idx;
  assign bus.valid_o = w_valid;
  assign bus.last_o  = w_last;
  assign bus.gnt_o   = w_acc ? w_idx_oh : '0;
  assign bus.data_o  = EnDataPort ? bus.data_i[w_idx] : '1;

  assign dbg_st_o  = r_st;
  assign dbg_ptr_o = r_ptr;

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.gnt_o));
  a_gnt_ready : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.gnt_o != '0) |-> bus.ready_i);
  a_hold_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_valid && !bus.ready_i) |=> $stable(w_idx));
  a_hold_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_st == ArbBusy && !w_done) |=> $stable(w_idx));
  m_req_stable : assume property (@(posedge clk_i) disable iff (!rst_ni)
    ((bus.req_i & ~bus.gnt_o) != '0) |=>
      (($past(bus.req_i & ~bus.gnt_o) & ~bus.req_i) == '0));

endmodule
